// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared definitions for the 16:1 round-robin arbiter slice.
//   N_REQ      : number of requesters sharing the output channel
//   SEL_W      : width of the mux select / requester index
//   state_t    : arbiter state (IDLE, XFER)
//   hold_cnt_w : width of the per-grant transfer counter for a given MAX_HOLD
package mux16_rr_arbiter_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Counter must be able to hold the value MAX_HOLD itself.
    function automatic int hold_cnt_w(input int max_hold);
        return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/mux16_rr_arbiter_pick.sv
// rr_pick16: combinational round-robin priority pick.
//   req   : request vector, one bit per requester
//   ptr   : index with highest priority this round
//   found : any request pending
//   idx   : first requester with req set, scanning ptr, ptr+1, ... wrapping 15->0
module rr_pick16
    import mux16_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] off;

    always_comb begin
        // Rotating the doubled vector puts requester ptr at bit 0, so a
        // plain lowest-set-bit search gives the offset from ptr.
        rot   = N_REQ'({req, req} >> ptr);
        found = |req;
        off   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
        // Index arithmetic wraps naturally in SEL_W bits.
        idx = ptr + off;
    end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin arbiter/sequencer sharing one DATA_W-bit
// output channel among 16 requesters, with bursts bounded by MAX_HOLD.
//   clk, rst_n : clock, synchronous active-low reset
//   req        : per-requester request, held with stable data until ack
//   data_in    : packed payloads, requester i at [i*DATA_W +: DATA_W]
//   grant      : one-hot current owner, zero when idle
//   select     : index of the current owner (16-way mux select)
//   out_data   : payload of the current owner
//   out_valid  : transfer offered downstream
//   out_ready  : downstream accepts when high together with out_valid
//   ack        : one-hot pulse for the requester whose transfer was accepted
//   busy       : high while a grant is active
module mux16_rr_arbiter
    import mux16_rr_arbiter_pkg::*;
#(
    parameter int DATA_W   = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] data_in,
    output logic [N_REQ-1:0]        grant,
    output logic [SEL_W-1:0]        select,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_REQ-1:0]        ack,
    output logic                    busy
);

    localparam int                HOLD_W   = hold_cnt_w(MAX_HOLD);
    localparam logic [HOLD_W-1:0] LAST_CNT = HOLD_W'(MAX_HOLD - 1);

    state_t            state, state_nx;
    logic [SEL_W-1:0]  ptr, ptr_nx;
    logic [SEL_W-1:0]  sel, sel_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nx;
    logic              found;
    logic [SEL_W-1:0]  pick_idx;
    logic              in_xfer;
    logic              handshake;

    rr_pick16 u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (found),
        .idx   (pick_idx)
    );

    assign in_xfer = (state == XFER);

    // Outputs: decoded from registered state; only out_valid/ack see req.
    // rst_n gates the offer so no transfer can be accepted on a reset edge.
    always_comb begin
        grant     = '0;
        select    = '0;
        out_data  = '0;
        out_valid = 1'b0;
        busy      = 1'b0;
        if (in_xfer) begin
            grant     = N_REQ'(1) << sel;
            select    = sel;
            out_data  = data_in[sel*DATA_W +: DATA_W];
            out_valid = req[sel] & rst_n;
            busy      = 1'b1;
        end
        handshake = out_valid & out_ready;
        ack       = handshake ? grant : '0;
    end

    // Next-state: a grant ends on withdrawal or on the MAX_HOLD-th transfer,
    // and always hands priority to the requester after the owner.
    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        sel_nx      = sel;
        hold_cnt_nx = hold_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    sel_nx      = pick_idx;
                    hold_cnt_nx = '0;
                    state_nx    = XFER;
                end
            end
            XFER: begin
                if (!req[sel]) begin
                    state_nx    = IDLE;
                    ptr_nx      = sel + SEL_W'(1);
                    hold_cnt_nx = '0;
                end else if (handshake) begin
                    if (hold_cnt == LAST_CNT) begin
                        state_nx    = IDLE;
                        ptr_nx      = sel + SEL_W'(1);
                        hold_cnt_nx = '0;
                    end else begin
                        hold_cnt_nx = hold_cnt + HOLD_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            sel      <= sel_nx;
            hold_cnt <= hold_cnt_nx;
        end
    end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Self-checking bench for mux16_rr_arbiter: directed scenarios followed by
// randomized traffic, all checked every cycle against a behavioural model.
module tb_mux16_rr_arbiter;

    localparam int DATA_W   = 2;
    localparam int MAX_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic [31:0] data_in;
    logic [15:0] grant;
    logic [3:0]  select;
    logic [1:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] ack;
    logic        busy;

    mux16_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .grant     (grant),
        .select    (select),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ack       (ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: owner = -1 means no grant in progress.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;

    // Values sampled during the most recent cycle.
    logic [15:0] s_grant, s_ack;
    logic [3:0]  s_select;
    logic [1:0]  s_data;
    logic        s_valid, s_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < 16; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % 16]) begin
                    m_owner = (m_ptr + k) % 16;
                end
            end
            m_cnt = 0;
        end else if (!req[m_owner]) begin
            m_ptr   = (m_owner + 1) % 16;
            m_owner = -1;
            m_cnt   = 0;
        end else if (out_ready) begin
            m_cnt++;
            if (m_cnt == MAX_HOLD) begin
                m_ptr   = (m_owner + 1) % 16;
                m_owner = -1;
                m_cnt   = 0;
            end
        end
    endtask

    // One clock: inputs are already set; sample and check at negedge,
    // then advance the model at the rising edge.
    task automatic cycle();
        logic [15:0] e_grant;
        logic [3:0]  e_select;
        logic [1:0]  e_data;
        logic        e_valid;
        @(negedge clk);
        e_grant  = '0;
        e_select = '0;
        e_data   = '0;
        e_valid  = 1'b0;
        if (m_owner >= 0) begin
            e_grant  = 16'(1) << m_owner;
            e_select = 4'(m_owner);
            e_data   = data_in[m_owner*2 +: 2];
            e_valid  = rst_n & req[m_owner];
        end
        s_grant  = grant;
        s_select = select;
        s_data   = out_data;
        s_valid  = out_valid;
        s_ack    = ack;
        s_busy   = busy;
        check("model_grant", 32'(grant), 32'(e_grant));
        check("model_select", 32'(select), 32'(e_select));
        check("model_data", 32'(out_data), 32'(e_data));
        check("model_valid", 32'(out_valid), 32'(e_valid));
        check("model_ack", 32'(ack), (e_valid && out_ready) ? 32'(e_grant) : 32'd0);
        check("model_busy", 32'(busy), 32'(m_owner >= 0));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic go_idle();
        req = '0;
        cycle();
        cycle();
        check("go_idle_busy", 32'(s_busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        data_in   = $urandom;
        out_ready = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        cycle();
        check("reset_grant", 32'(s_grant), 32'd0);
        check("reset_valid", 32'(s_valid), 32'd0);
        rst_n = 1'b1;

        // Idle for 10 cycles with no requests.
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("idle_busy", 32'(s_busy), 32'd0);
            check("idle_grant", 32'(s_grant), 32'd0);
        end

        // Requesters 0 and 5: bursts of MAX_HOLD with one bubble between.
        req       = 16'h0021;
        out_ready = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("burst0_ack", 32'(s_ack), 32'h0001);
        end
        cycle();
        check("bubble0_grant", 32'(s_grant), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("burst5_select", 32'(s_select), 32'd5);
            check("burst5_ack", 32'(s_ack), 32'h0020);
        end
        cycle();
        check("bubble5_grant", 32'(s_grant), 32'd0);
        cycle();
        check("back_to0_select", 32'(s_select), 32'd0);
        check("back_to0_ack", 32'(s_ack), 32'h0001);
        go_idle();

        // Pointer wrap: withdraw 14 to put ptr at 15, then 15 before 0.
        req = 16'h4000;
        cycle();
        req = 16'h8001;
        cycle();
        check("withdraw14_valid", 32'(s_valid), 32'd0);
        check("withdraw14_ack", 32'(s_ack), 32'd0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("wrap15_select", 32'(s_select), 32'd15);
        end
        cycle();
        cycle();
        check("wrap0_select", 32'(s_select), 32'd0);
        check("wrap0_grant", 32'(s_grant), 32'h0001);
        go_idle();

        // Requester 3 stalled by out_ready, then accepted once.
        req       = 16'h0008;
        out_ready = 1'b0;
        data_in   = $urandom;
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("stall3_valid", 32'(s_valid), 32'd1);
            check("stall3_ack", 32'(s_ack), 32'd0);
        end
        out_ready = 1'b1;
        cycle();
        check("accept3_ack", 32'(s_ack), 32'h0008);
        check("accept3_data", 32'(s_data), 32'(data_in[7:6]));
        out_ready = 1'b0;
        cycle();
        check("after3_ack", 32'(s_ack), 32'd0);
        go_idle();

        // Requester 7 withdraws before any handshake: ptr moves to 8.
        req = 16'h0080;
        cycle();
        req       = '0;
        out_ready = 1'b1;
        cycle();
        check("withdraw7_valid", 32'(s_valid), 32'd0);
        check("withdraw7_ack", 32'(s_ack), 32'd0);
        check("withdraw7_busy", 32'(s_busy), 32'd1);
        cycle();
        check("withdraw7_idle", 32'(s_busy), 32'd0);
        req = 16'h0101;
        cycle();
        cycle();
        check("ptr8_select", 32'(s_select), 32'd8);
        go_idle();

        // Reset mid-burst with hold_cnt = 2; ptr must return to 0.
        req = 16'h0004;
        cycle();
        cycle();
        cycle();
        rst_n = 1'b0;
        cycle();
        check("reset_burst_ack", 32'(s_ack), 32'd0);
        rst_n = 1'b1;
        req   = 16'h0204;
        cycle();
        check("post_reset_grant", 32'(s_grant), 32'd0);
        check("post_reset_select", 32'(s_select), 32'd0);
        check("post_reset_valid", 32'(s_valid), 32'd0);
        cycle();
        check("post_reset_pick", 32'(s_select), 32'd2);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = 16'($urandom & $urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                data_in = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
